// File: rtl/bf16_accumulator.sv
// bf16_accumulator: reduces a valid/ready stream of bfloat16 products into one truncated bf16 sum per in_last group.
// Optional macro BF16_ACC_SPECIALS_EN: honour Inf/NaN and overflow to Inf; otherwise exp=255 clamps and overflow saturates.
module bf16_accumulator #(
    parameter int DATA_TYPE = 16,
    parameter int CNT_W     = 11
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_TYPE-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_TYPE-1:0] out_data,
    output logic [CNT_W-1:0]     out_count
);
    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_reg;
    logic [15:0]      acc_reg;
    logic [15:0]      out_data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [15:0]      sum_next;

    logic       a_s, b_s;
    logic [7:0] a_e, b_e;
    logic [6:0] a_m, b_m;
`ifdef BF16_ACC_SPECIALS_EN
    logic a_nan, b_nan, a_inf, b_inf;
`endif

    always_comb begin
        {a_s, a_e, a_m} = acc_reg;
        {b_s, b_e, b_m} = in_data;
`ifdef BF16_ACC_SPECIALS_EN
        a_nan = (a_e == 8'hFF) && (a_m != 7'd0);
        b_nan = (b_e == 8'hFF) && (b_m != 7'd0);
        a_inf = (a_e == 8'hFF) && (a_m == 7'd0);
        b_inf = (b_e == 8'hFF) && (b_m == 7'd0);
`else
        // Without special values an all-ones exponent is just the largest finite magnitude
        if (a_e == 8'hFF) begin
            a_e = 8'hFE;
            a_m = 7'h7F;
        end
        if (b_e == 8'hFF) begin
            b_e = 8'hFE;
            b_m = 7'h7F;
        end
`endif
    end

    logic       swap, big_s, found;
    logic [7:0] big_e, small_e, exp_diff;
    logic [6:0] big_m, small_m, man_res, norm;
    logic [7:0] small_sh, sub_diff;
    logic [8:0] add_sum, exp_res;
    logic [2:0] lz;

    always_comb begin
        swap     = {b_e, b_m} > {a_e, a_m};
        big_s    = swap ? b_s : a_s;
        big_e    = swap ? b_e : a_e;
        big_m    = swap ? b_m : a_m;
        small_e  = swap ? a_e : b_e;
        small_m  = swap ? a_m : b_m;
        exp_diff = big_e - small_e;
        small_sh = (exp_diff > 8'd7) ? 8'h00 : ({1'b1, small_m} >> exp_diff);
        add_sum  = {1'b0, 1'b1, big_m} + {1'b0, small_sh};
        sub_diff = {1'b1, big_m} - small_sh;
        lz       = 3'd0;
        found    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && sub_diff[i]) begin
                lz    = 3'(7 - i);
                found = 1'b1;
            end
        end
        // The leading one shifts into bit 7 and is dropped as the hidden bit
        norm     = sub_diff[6:0] << lz;
        exp_res  = 9'd0;
        man_res  = 7'd0;
        sum_next = 16'h0000;
        if (a_e == 8'd0 && b_e == 8'd0) begin
            sum_next = 16'h0000;
        end else if (a_e == 8'd0) begin
            sum_next = {b_s, b_e, b_m};
        end else if (b_e == 8'd0) begin
            sum_next = {a_s, a_e, a_m};
        end else if (a_s == b_s) begin
            if (add_sum[8]) begin
                exp_res = {1'b0, big_e} + 9'd1;
                man_res = add_sum[7:1];
            end else begin
                exp_res = {1'b0, big_e};
                man_res = add_sum[6:0];
            end
            if (exp_res >= 9'd255) begin
`ifdef BF16_ACC_SPECIALS_EN
                sum_next = {big_s, 15'h7F80};
`else
                sum_next = {big_s, 15'h7F7F};
`endif
            end else begin
                sum_next = {big_s, exp_res[7:0], man_res};
            end
        end else if (found && ({1'b0, big_e} > {6'd0, lz})) begin
            exp_res  = {1'b0, big_e} - {6'd0, lz};
            sum_next = {big_s, exp_res[7:0], norm};
        end
`ifdef BF16_ACC_SPECIALS_EN
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            sum_next = 16'h7FC0;
        end else if (a_inf) begin
            sum_next = {a_s, 15'h7F80};
        end else if (b_inf) begin
            sum_next = {b_s, 15'h7F80};
        end
`endif
    end

    assign cnt_next  = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign in_ready  = (state_reg == ST_ACC) && !rst;
    assign out_valid = (state_reg == ST_HOLD) && !rst;
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg     <= ST_ACC;
            acc_reg       <= 16'h0000;
            cnt_reg       <= '0;
            out_data_reg  <= 16'h0000;
            out_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_data_reg  <= sum_next;
                            out_count_reg <= cnt_next;
                            acc_reg       <= 16'h0000;
                            cnt_reg       <= '0;
                            state_reg     <= ST_HOLD;
                        end else begin
                            acc_reg <= sum_next;
                            cnt_reg <= cnt_next;
                        end
                    end
                end
                default: begin
                    if (out_ready) state_reg <= ST_ACC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_accumulator.sv
// Directed and randomised checks of bf16_accumulator against hand-computed values and a truncating bf16 model.
module tb_bf16_accumulator;
    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [10:0] out_count;

    logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
    logic [15:0] s_in_data = 16'h0000;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [2:0]  s_out_count;

    int checks = 0;
    int errors = 0;
    bit drv_done = 1'b0;

    typedef struct {
        logic [15:0] data;
        int          count;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    bf16_accumulator #(.DATA_TYPE(16), .CNT_W(11)) u_dut (
        .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count)
    );

    bf16_accumulator #(.DATA_TYPE(16), .CNT_W(3)) u_dut_sat (
        .CLK(CLK), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_count(s_out_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [15:0] pack(input int s, input int e, input int m);
        return 16'((s << 15) | (e << 7) | m);
    endfunction

    // Reference bf16 add: align with discarded guard bits, truncate, flush denormals
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int sa, ea, ma, sb, eb, mb, sbig, ebig, mbig, esm, msm, d, m, e;
        sa = int'(a[15]); ea = int'(a[14:7]); ma = int'(a[6:0]);
        sb = int'(b[15]); eb = int'(b[14:7]); mb = int'(b[6:0]);
`ifdef BF16_ACC_SPECIALS_EN
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 16'h7FC0;
        if (ea == 255 && eb == 255) return (sa == sb) ? a : 16'h7FC0;
        if (ea == 255) return a;
        if (eb == 255) return b;
`else
        if (ea == 255) begin ea = 254; ma = 127; end
        if (eb == 255) begin eb = 254; mb = 127; end
`endif
        if (ea == 0 && eb == 0) return 16'h0000;
        if (ea == 0) return pack(sb, eb, mb);
        if (eb == 0) return pack(sa, ea, ma);
        if (ea * 128 + ma >= eb * 128 + mb) begin
            sbig = sa; ebig = ea; mbig = ma + 128; esm = eb; msm = mb + 128;
        end else begin
            sbig = sb; ebig = eb; mbig = mb + 128; esm = ea; msm = ma + 128;
        end
        d = ebig - esm;
        msm = (d > 7) ? 0 : (msm >> d);
        e = ebig;
        if (sa == sb) begin
            m = mbig + msm;
            if (m > 255) begin m = m >> 1; e++; end
`ifdef BF16_ACC_SPECIALS_EN
            if (e > 254) return pack(sbig, 255, 0);
`else
            if (e > 254) return pack(sbig, 254, 127);
`endif
        end else begin
            m = mbig - msm;
            if (m == 0) return 16'h0000;
            while (m < 128) begin m = m << 1; e--; end
            if (e < 1) return 16'h0000;
        end
        return pack(sbig, e, m & 127);
    endfunction

    function automatic logic [15:0] rand_bf16();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'h8000;
        if (r == 2) return {1'($urandom), 8'h00, 7'($urandom)};
        return {1'($urandom), 8'($urandom_range(118, 134)), 7'($urandom)};
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted
    task automatic send_beat(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge CLK);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic expect_sum(input string tag, input logic [15:0] d, input int c);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_driver();
        int len, beats;
        logic [15:0] acc_m, d;
        exp_t e;
        beats = 0;
        while (beats < 1000) begin
            len = int'($urandom_range(1, 12));
            acc_m = 16'h0000;
            for (int k = 0; k < len; k++) begin
                d = rand_bf16();
                acc_m = ref_add(acc_m, d);
                if (k == len - 1) begin
                    e.data = acc_m; e.count = len;
                    exp_q.push_back(e);
                end
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                send_beat(d, k == len - 1);
            end
            beats += len;
        end
        drv_done = 1'b1;
    endtask

    task automatic run_monitor();
        int cyc;
        exp_t e;
        cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 30000) begin
            @(negedge CLK);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_data", 32'(out_data), 32'(e.data));
                    check("rand_count", 32'(out_count), 32'(e.count));
                end
            end
        end
        @(negedge CLK);
        out_ready = 1'b0;
        if (!drv_done || exp_q.size() != 0) check("rand_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // 3 + 3.125 = 6.125, visible one cycle after the last beat
        send_beat(16'h4040, 1'b0);
        check("t1_no_early_valid", 32'(out_valid), 32'd0);
        send_beat(16'h4048, 1'b1);
        expect_sum("t1", 16'h40C4, 2);

        send_beat(16'h4040, 1'b0); send_beat(16'hC040, 1'b1);
        expect_sum("t2_cancel", 16'h0000, 2);
        send_beat(16'h4380, 1'b0); send_beat(16'h3F80, 1'b1);
        expect_sum("t2_trunc", 16'h4380, 2);
        send_beat(16'h3F80, 1'b0); send_beat(16'h3F80, 1'b1);
        expect_sum("t2_one_one", 16'h4000, 2);

        // Backpressure: a pending beat must not be consumed while the sum is held
        send_beat(16'h4040, 1'b0); send_beat(16'h4048, 1'b1);
        in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t3_hold_data", 32'(out_data), 32'h40C4);
            check("t3_hold_in_ready", 32'(in_ready), 32'd0);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check("t3_release_in_ready", 32'(in_ready), 32'd1);
        send_beat(16'h461B, 1'b1);
        expect_sum("t3_single", 16'h461B, 1);

`ifdef BF16_ACC_SPECIALS_EN
        send_beat(16'h7F80, 1'b0); send_beat(16'hFF80, 1'b1);
        expect_sum("t4_inf_minus_inf", 16'h7FC0, 2);
        send_beat(16'h7FC1, 1'b0); send_beat(16'h3F80, 1'b1);
        expect_sum("t4_nan", 16'h7FC0, 2);
        send_beat(16'h7F7F, 1'b0); send_beat(16'h7F7F, 1'b1);
        expect_sum("t4_overflow", 16'h7F80, 2);
`else
        send_beat(16'h7F80, 1'b0); send_beat(16'hFF80, 1'b1);
        expect_sum("t4_clamp_cancel", 16'h0000, 2);
        send_beat(16'hFF80, 1'b1);
        expect_sum("t4_clamp_single", 16'hFF7F, 1);
        send_beat(16'h7F7F, 1'b0); send_beat(16'h7F7F, 1'b1);
        expect_sum("t4_overflow", 16'h7F7F, 2);
`endif

        // Reset mid-group discards the partial sum and clears the held result
        send_beat(16'h4B00, 1'b0); send_beat(16'h4B00, 1'b0);
        rst = 1'b1;
        @(negedge CLK);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd0);
        check("t5_rst_out_data", 32'(out_data), 32'd0);
        check("t5_rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        @(negedge CLK);
        check("t5_after_in_ready", 32'(in_ready), 32'd1);
        check("t5_after_out_data", 32'(out_data), 32'd0);
        send_beat(16'h4040, 1'b1);
        expect_sum("t5", 16'h4040, 1);

        // Count saturation on the 3-bit counter instance: nine ones sum to 9.0
        for (int i = 0; i < 9; i++) begin
            s_in_valid = 1'b1; s_in_data = 16'h3F80; s_in_last = (i == 8);
            @(negedge CLK);
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        check("t6_sat_valid", 32'(s_out_valid), 32'd1);
        check("t6_sat_data", 32'(s_out_data), 32'h4110);
        check("t6_sat_count", 32'(s_out_count), 32'd7);
        s_out_ready = 1'b1;
        @(negedge CLK);
        s_out_ready = 1'b0;

        fork
            run_driver();
            run_monitor();
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
